hazard_controller: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV32I core. Takes per-stage register-usage and control fields from the decode outputs as they travel down the pipeline. Produces the stall, bubble, flush and forwarding-select signals that sequence IF/ID/EX/MEM/WB. Owns the data-memory wait state machine with a timeout, plus stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_forward_select.sv | 22 ++
 rtl/hazard_controller.sv | 146 ++++++++++++++
 tb/tb_hazard_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_forward_select.sv
// EX operand bypass select for one source register; the youngest producer (MEM) wins.
module forward_select
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward sequencing for the 5-stage RV32I pipeline, with the
// data-memory wait FSM, its timeout and the stall/flush performance counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic             ID_uses_rs1_i,
    input  logic             ID_uses_rs2_i,
    input  logic [4:0]       EX_rs1_i,
    input  logic [4:0]       EX_rs2_i,
    input  logic [4:0]       EX_rd_i,
    input  logic             EX_Reg_write_i,
    input  logic             EX_Rd_source_i,
    input  logic [4:0]       MEM_rd_i,
    input  logic [4:0]       WB_rd_i,
    input  logic             MEM_Reg_write_i,
    input  logic             WB_Reg_write_i,
    input  logic             EX_redirect_i,
    input  logic             MEM_access_i,
    input  logic             dmem_ready_i,
    output logic             stall_IF_o,
    output logic             stall_ID_o,
    output logic             stall_EX_o,
    output logic             stall_MEM_o,
    output logic             bubble_EX_o,
    output logic             bubble_WB_o,
    output logic             flush_ID_o,
    output logic             flush_EX_o,
    output logic [1:0]       forward_A_o,
    output logic [1:0]       forward_B_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    localparam int unsigned WAIT_W    = $clog2(TIMEOUT_CYCLES + 2);
    // The RUN cycle that raises the stall is the first not-ready cycle, so
    // MEM_WAIT only has to count TIMEOUT_CYCLES-1 more before giving up.
    localparam int unsigned WAIT_LAST = (TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_error;
    logic              memstall;
    logic              load_use;

    assign in_error = (state == ERROR);
    assign memstall = MEM_access_i & ~dmem_ready_i & ~in_error;
    assign load_use = EX_Rd_source_i & EX_Reg_write_i & (EX_rd_i != 5'd0) &
                      ((ID_uses_rs1_i & (ID_rs1_i == EX_rd_i)) |
                       (ID_uses_rs2_i & (ID_rs2_i == EX_rd_i)));

    always_comb begin
        stall_IF_o  = 1'b0;
        stall_ID_o  = 1'b0;
        stall_EX_o  = 1'b0;
        stall_MEM_o = 1'b0;
        bubble_EX_o = 1'b0;
        bubble_WB_o = 1'b0;
        flush_ID_o  = 1'b0;
        flush_EX_o  = 1'b0;
        if (memstall || in_error) begin
            stall_IF_o  = 1'b1;
            stall_ID_o  = 1'b1;
            stall_EX_o  = 1'b1;
            stall_MEM_o = 1'b1;
            bubble_WB_o = 1'b1;
        end else if (EX_redirect_i) begin
            flush_ID_o = 1'b1;
            flush_EX_o = 1'b1;
        end else if (load_use) begin
            stall_IF_o  = 1'b1;
            stall_ID_o  = 1'b1;
            bubble_EX_o = 1'b1;
        end
    end

    forward_select u_fwd_a (
        .rs            (EX_rs1_i),
        .mem_rd        (MEM_rd_i),
        .mem_reg_write (MEM_Reg_write_i),
        .wb_rd         (WB_rd_i),
        .wb_reg_write  (WB_Reg_write_i),
        .fwd_sel       (forward_A_o)
    );

    forward_select u_fwd_b (
        .rs            (EX_rs2_i),
        .mem_rd        (MEM_rd_i),
        .mem_reg_write (MEM_Reg_write_i),
        .wb_rd         (WB_rd_i),
        .wb_reg_write  (WB_Reg_write_i),
        .fwd_sel       (forward_B_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= RUN;
            wait_cnt      <= '0;
            mem_timeout_o <= 1'b0;
            stall_count_o <= '0;
            flush_count_o <= '0;
        end else begin
            if (stall_IF_o) stall_count_o <= stall_count_o + CNT_W'(1);
            if (flush_ID_o) flush_count_o <= flush_count_o + CNT_W'(1);

            unique case (state)
                RUN: begin
                    if (memstall) begin
                        wait_cnt <= '0;
                        if (TIMEOUT_CYCLES == 1) begin
                            state         <= ERROR;
                            mem_timeout_o <= 1'b1;
                        end else begin
                            state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!memstall) begin
                        state <= RUN;
                    end else if ((TIMEOUT_CYCLES >= 2) && (wait_cnt == WAIT_W'(WAIT_LAST))) begin
                        state         <= ERROR;
                        mem_timeout_o <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: driver queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_controller;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_u1, id_u2, ex_rw, ex_src, mem_rw, wb_rw, redir, access, ready;
    logic        s_if, s_id, s_ex, s_mem, b_ex, b_wb, f_id, f_ex, tmo;
    logic [1:0]  fa, fb;
    logic [15:0] scnt, fcnt;

    typedef struct {
        string       name;
        logic [12:0] outs;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_controller #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2),
        .ID_uses_rs1_i(id_u1), .ID_uses_rs2_i(id_u2),
        .EX_rs1_i(ex_rs1), .EX_rs2_i(ex_rs2), .EX_rd_i(ex_rd),
        .EX_Reg_write_i(ex_rw), .EX_Rd_source_i(ex_src),
        .MEM_rd_i(mem_rd), .WB_rd_i(wb_rd),
        .MEM_Reg_write_i(mem_rw), .WB_Reg_write_i(wb_rw),
        .EX_redirect_i(redir), .MEM_access_i(access), .dmem_ready_i(ready),
        .stall_IF_o(s_if), .stall_ID_o(s_id), .stall_EX_o(s_ex), .stall_MEM_o(s_mem),
        .bubble_EX_o(b_ex), .bubble_WB_o(b_wb),
        .flush_ID_o(f_id), .flush_EX_o(f_ex),
        .forward_A_o(fa), .forward_B_o(fb),
        .mem_timeout_o(tmo),
        .stall_count_o(scnt), .flush_count_o(fcnt)
    );

    // {stall IF,ID,EX,MEM, bubble EX,WB, flush ID,EX, fwd A, fwd B, timeout}
    function automatic logic [12:0] mk(input logic sif, input logic sid, input logic sex,
                                       input logic smem, input logic bex, input logic bwb,
                                       input logic fid, input logic fex, input logic [1:0] a,
                                       input logic [1:0] b, input logic to);
        return {sif, sid, sex, smem, bex, bwb, fid, fex, a, b, to};
    endfunction

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; id_u1 = 1'b0; id_u2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_rw = 1'b0; ex_src = 1'b0;
        mem_rd = '0; wb_rd = '0; mem_rw = 1'b0; wb_rw = 1'b0;
        redir = 1'b0; access = 1'b0; ready = 1'b0;
    endtask

    task automatic step(input string nm, input logic [12:0] o,
                        input int unsigned sc, input int unsigned fc);
        exp_t e;
        e.name = nm; e.outs = o; e.sc = 16'(sc); e.fc = 16'(fc);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        ex_rd = 5'd5; ex_rw = 1'b1; ex_src = 1'b1;
        id_rs1 = 5'd5; id_u1 = 1'b1; id_rs2 = 5'd1; id_u2 = 1'b1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [12:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {s_if, s_id, s_ex, s_mem, b_ex, b_wb, f_id, f_ex, fa, fb, tmo};
                checks++;
                if (act !== e.outs || scnt !== e.sc || fcnt !== e.fc) begin
                    errors++;
                    $display("FAIL %s: outs=%b sc=%0d fc=%0d, expected outs=%b sc=%0d fc=%0d",
                             e.name, act, scnt, fcnt, e.outs, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : driver
        logic [12:0] zero, memst, err, flush, lu;
        zero  = mk(L,L,L,L,L,L,L,L,2'b00,2'b00,L);
        memst = mk(H,H,H,H,L,H,L,L,2'b00,2'b00,L);
        err   = mk(H,H,H,H,L,H,L,L,2'b00,2'b00,H);
        flush = mk(L,L,L,L,L,L,H,H,2'b00,2'b00,L);
        lu    = mk(H,H,L,L,H,L,L,L,2'b00,2'b00,L);

        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        step("reset", zero, 0, 0);
        rst = 1'b0;

        // lw x5 in EX, add x6,x5,x1 in ID
        set_load_use();
        step("load_use", lu, 0, 0);
        idle();
        ex_rs1 = 5'd5; ex_rs2 = 5'd1; ex_rd = 5'd6; ex_rw = 1'b1;
        wb_rd = 5'd5; wb_rw = 1'b1;
        step("lu_fwd_wb", mk(L,L,L,L,L,L,L,L,2'b01,2'b00,L), 1, 0);

        idle();
        ex_rs2 = 5'd3; mem_rd = 5'd3; mem_rw = 1'b1; wb_rd = 5'd3; wb_rw = 1'b1;
        step("fwd_mem_pri", mk(L,L,L,L,L,L,L,L,2'b00,2'b10,L), 1, 0);
        mem_rw = 1'b0;
        step("fwd_wb_only", mk(L,L,L,L,L,L,L,L,2'b00,2'b01,L), 1, 0);
        mem_rd = 5'd0; mem_rw = 1'b1; wb_rd = 5'd0; ex_rs2 = 5'd0;
        step("fwd_x0", zero, 1, 0);

        idle();
        redir = 1'b1;
        step("redirect", flush, 1, 0);
        idle();
        step("post_redirect", zero, 1, 1);
        set_load_use(); redir = 1'b1;
        step("redir_vs_lu", flush, 1, 1);
        idle();
        step("post_redir2", zero, 1, 2);

        access = 1'b1;
        step("mw_0", memst, 1, 2);
        redir = 1'b1;
        step("mw_1_redir", memst, 2, 2);
        redir = 1'b0;
        step("mw_2", memst, 3, 2);
        ready = 1'b1;
        step("mw_ready", zero, 4, 2);
        idle();
        step("post_ready", zero, 4, 2);

        access = 1'b1;
        step("to_t0", memst, 4, 2);
        step("to_t1", memst, 5, 2);
        step("to_t2", memst, 6, 2);
        step("to_t3", memst, 7, 2);
        step("to_err", err, 8, 2);
        access = 1'b0;
        step("err_hold", err, 9, 2);
        access = 1'b1; ready = 1'b1;
        step("err_ready", err, 10, 2);

        idle();
        #2 rst = 1'b1;
        step("async_reset", zero, 0, 0);
        rst = 1'b0;
        step("post_reset", zero, 0, 0);
        redir = 1'b1;
        step("redir_after_rst", flush, 0, 0);
        idle();
        step("post_redir_rst", zero, 0, 1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending=%0d, expected pending=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
